// File: rtl/program_counter_core.sv
// ---------------------------------------------------------------------------
// program_counter_core
//
// Parameterisable program counter with synchronous load, count enable and a
// one-cycle wrap pulse on increment overflow.
//
// Priority at each rising clk edge: reset > load > en > hold.
//
// Optional feature (macro PC_WRAP_COUNT_EN):
//   defined   -> wrap_count counts wrap pulses, saturating at 255, cleared
//                by reset.
//   undefined -> wrap_count is tied to 0 and no counter logic exists; the
//                port list does not change.
//
// Power-up: pc starts at RESET_VALUE and wrap/wrap_count at 0 through
// register initialisers, so pc is defined before the first clock edge even
// if reset is released without ever seeing an edge.
//
// STEP is expected to be below 2**WIDTH; the increment is formed one bit
// wider than the counter so the carry out is the wrap condition.
// ---------------------------------------------------------------------------
module program_counter_core #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0,
    parameter int STEP        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en        = 1'b1,
    input  logic             load      = 1'b0,
    input  logic [WIDTH-1:0] load_addr = '0,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             wrap,
    output logic [7:0]       wrap_count
);

    // Reset value and step truncated/extended to the widths they are used at.
    localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);

    // NOTE: declaration initialisers give the power-up state; they are not a
    // substitute for reset, which still drives the same values explicitly.
    logic [WIDTH-1:0] pc_q   = RST_PC;
    logic             wrap_q = 1'b0;

    logic [WIDTH:0]   inc_sum;
    logic             wrap_set;

    // Widened increment: the extra top bit is the unsigned carry out.
    always_comb begin
        inc_sum = {1'b0, pc_q} + STEP_EXT;
    end

    // Next-pc selection (load > en > hold); reset is applied only in the register.
    always_comb begin
        // NOTE: default assignment first so every path drives pc_next and no
        // latch is inferred.
        pc_next  = pc_q;
        wrap_set = 1'b0;
        if (load) begin
            pc_next = load_addr;
        end else if (en) begin
            pc_next  = inc_sum[WIDTH-1:0];
            wrap_set = inc_sum[WIDTH];
        end
    end

    // State register for pc and the one-cycle wrap pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc_q   <= RST_PC;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_next;
            wrap_q <= wrap_set;
        end
    end

    assign pc   = pc_q;
    assign wrap = wrap_q;

`ifdef PC_WRAP_COUNT_EN
    logic [7:0] wrap_count_q = 8'd0;

    // Saturating wrap counter, updated on the same edge that raises wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_count_q <= 8'd0;
        end else if (wrap_set && (wrap_count_q != 8'hFF)) begin
            wrap_count_q <= wrap_count_q + 8'd1;
        end
    end

    assign wrap_count = wrap_count_q;
`else
    assign wrap_count = 8'd0;
`endif

endmodule

// File: tb/tb_program_counter_core.sv
// ---------------------------------------------------------------------------
// tb_program_counter_core
//
// Self-checking bench for program_counter_core with default parameters.
// A reference model holds the counter as a plain integer and applies the
// reset/load/en/hold rules with modular arithmetic. Outputs are sampled 1 ns
// after each rising edge; inputs change right after sampling.
// Honours PC_WRAP_COUNT_EN for the wrap_count expectation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_counter_core;

    localparam int WIDTH       = 4;
    localparam int RESET_VALUE = 0;
    localparam int STEP        = 1;
    localparam int MODULUS     = 1 << WIDTH;

    logic             clk;
    logic             reset;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic             wrap;
    logic [7:0]       wrap_count;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_pc   = RESET_VALUE;
    int m_wrap = 0;
    int m_cnt  = 0;

    program_counter_core #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE),
        .STEP       (STEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .load_addr (load_addr),
        .pc        (pc),
        .pc_next   (pc_next),
        .wrap      (wrap),
        .wrap_count(wrap_count)
    );

    // Clock held low for the power-up window, first rising edge at 25 ns.
    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    // Expected wrap_count depends on whether the optional counter is built.
    function automatic int exp_cnt();
`ifdef PC_WRAP_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Expected pc_next from the current inputs and model pc (reset ignored).
    function automatic int exp_next();
        if (load) return int'(load_addr);
        if (en)   return (m_pc + STEP) % MODULUS;
        return m_pc;
    endfunction

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        if (reset) begin
            m_pc   = RESET_VALUE;
            m_wrap = 0;
            m_cnt  = 0;
        end else if (load) begin
            m_pc   = int'(load_addr);
            m_wrap = 0;
        end else if (en) begin
            m_wrap = ((m_pc + STEP) >= MODULUS) ? 1 : 0;
            m_pc   = (m_pc + STEP) % MODULUS;
            if (m_wrap == 1 && m_cnt < 255) m_cnt++;
        end else begin
            m_wrap = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; load = 1'b0; load_addr = '0;
        #10;
        reset = 1'b0;
        #2;
        tests++;
        if (pc !== WIDTH'(RESET_VALUE)) begin
            fails++;
            $display("FAIL powerup_pc: got %0d expected %0d", pc, RESET_VALUE);
        end
        tests++;
        if (wrap !== 1'b0 || wrap_count !== 8'd0) begin
            fails++;
            $display("FAIL powerup_flags: got wrap=%0d cnt=%0d expected 0/0", wrap, wrap_count);
        end
        m_pc = RESET_VALUE; m_wrap = 0; m_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (pc !== WIDTH'(m_pc)) begin
                fails++;
                $display("FAIL count_up[%0d]: got %0d expected %0d", i, pc, m_pc);
            end
        end
        tests++;
        if (pc !== 4'hA) begin
            fails++;
            $display("FAIL count_end: got %0h expected a", pc);
        end
    endtask

    task automatic test_reset_midcount();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (pc !== WIDTH'(RESET_VALUE) || wrap !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got pc=%0d wrap=%0d expected %0d/0", i, pc, wrap, RESET_VALUE);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        int seen = 0;
        en = 1'b1; load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (wrap === 1'b1) seen++;
            tests++;
            if (pc !== WIDTH'(m_pc) || wrap !== m_wrap[0]) begin
                fails++;
                $display("FAIL wrap_run[%0d]: got pc=%0d wrap=%0d expected %0d/%0d", i, pc, wrap, m_pc, m_wrap);
            end
        end
        tests++;
        if (seen != 1 || pc !== '0) begin
            fails++;
            $display("FAIL wrap_once: got pulses=%0d pc=%0d expected 1/0", seen, pc);
        end
        tests++;
        if (int'(wrap_count) != exp_cnt()) begin
            fails++;
            $display("FAIL wrap_count_one: got %0d expected %0d", wrap_count, exp_cnt());
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_addr = 4'd7; en = 1'b1;
        tick();
        tests++;
        if (pc !== 4'd7 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL load7: got pc=%0d wrap=%0d expected 7/0", pc, wrap);
        end
        load = 1'b0;
        tick();
        tests++;
        if (pc !== 4'd8) begin
            fails++;
            $display("FAIL after_load: got %0d expected 8", pc);
        end
        #1;
        tests++;
        if (pc_next !== 4'd9) begin
            fails++;
            $display("FAIL pc_next_9: got %0d expected 9", pc_next);
        end
        // Loading 0 from pc=15 with en high must not pulse wrap.
        load = 1'b1; load_addr = 4'd15;
        tick();
        load_addr = 4'd0;
        tick();
        tests++;
        if (pc !== 4'd0 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL load_zero_nowrap: got pc=%0d wrap=%0d expected 0/0", pc, wrap);
        end
        load = 1'b0;
    endtask

    task automatic test_hold();
        load = 1'b1; load_addr = 4'd5;
        tick();
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (pc !== 4'd5 || pc_next !== 4'd5 || wrap !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: got pc=%0d pc_next=%0d wrap=%0d expected 5/5/0", i, pc, pc_next, wrap);
            end
        end
        reset = 1'b1; load = 1'b1; load_addr = 4'd9; en = 1'b1;
        tick();
        tests++;
        if (pc !== WIDTH'(RESET_VALUE)) begin
            fails++;
            $display("FAIL reset_over_load: got %0d expected %0d", pc, RESET_VALUE);
        end
        reset = 1'b0; load = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            reset     = ($urandom_range(0, 19) == 0);
            load      = ($urandom_range(0, 4) == 0);
            en        = ($urandom_range(0, 3) != 0);
            load_addr = WIDTH'($urandom_range(0, MODULUS - 1));
            #1;
            tests++;
            if (int'(pc_next) != exp_next()) begin
                fails++;
                $display("FAIL rand_pc_next[%0d]: got %0d expected %0d", i, pc_next, exp_next());
            end
            tick();
            tests++;
            if (pc !== WIDTH'(m_pc) || wrap !== m_wrap[0]) begin
                fails++;
                $display("FAIL rand_state[%0d]: got pc=%0d wrap=%0d expected %0d/%0d", i, pc, wrap, m_pc, m_wrap);
            end
            if (m_wrap == 0) begin
                tests++;
                if (int'(wrap_count) != exp_cnt()) begin
                    fails++;
                    $display("FAIL rand_wrap_count[%0d]: got %0d expected %0d", i, wrap_count, exp_cnt());
                end
            end
        end
        reset = 1'b0; load = 1'b0; en = 1'b1;
    endtask

    task automatic test_wrap_count_saturation();
        int bad = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            load = 1'b1; load_addr = 4'd15; en = 1'b1;
            tick();
            load = 1'b0;
            tick();
            if (wrap !== 1'b1) bad++;
`ifndef PC_WRAP_COUNT_EN
            tests++;
            if (wrap_count !== 8'd0) begin
                fails++;
                $display("FAIL wrap_count_zero[%0d]: got %0d expected 0", i, wrap_count);
            end
`endif
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL sat_wrap_pulses: got %0d missing pulses expected 0", bad);
        end
        tick();
        tests++;
        if (int'(wrap_count) != exp_cnt()) begin
            fails++;
            $display("FAIL wrap_count_sat: got %0d expected %0d", wrap_count, exp_cnt());
        end
    endtask

    initial begin
        test_reset();
        test_reset_midcount();
        test_wrap();
        test_load();
        test_hold();
        test_random();
        test_wrap_count_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
